// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the MIPS-subset datapath: fetch/decode/execute/memory/writeback sequencing.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to trap on illegal opcodes/functs instead of retiring them as NOPs.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_ALU_WB    = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_EXEC_I    = 4'd10;
  localparam logic [3:0] S_IMM_WB    = 4'd11;
  localparam logic [3:0] S_JR        = 4'd12;
  localparam logic [3:0] S_TRAP      = 4'd13;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] FN_JR   = 6'h08;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_op_legal;
  logic       w_illegal;

  assign w_op_legal = (opcode == OP_R) || (opcode == OP_LW) || (opcode == OP_SW) ||
                      (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic w_funct_legal;
  assign w_funct_legal = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                         (funct == 6'h25) || (funct == 6'h2A) || (funct == FN_JR);
  assign w_illegal = !w_op_legal || ((opcode == OP_R) && !w_funct_legal);
`else
  assign w_illegal = !w_op_legal;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:     if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (w_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          w_next = S_TRAP;
`else
          w_next = S_FETCH;
`endif
        end else begin
          case (opcode)
            OP_LW, OP_SW: w_next = S_MEM_ADDR;
            OP_R:         w_next = (funct == FN_JR) ? S_JR : S_EXEC_R;
            OP_BEQ:       w_next = S_BRANCH;
            OP_J:         w_next = S_JUMP;
            OP_ADDI:      w_next = S_EXEC_I;
            default:      w_next = S_FETCH;
          endcase
        end
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      w_next = S_MEM_READ;
        else if (opcode == OP_SW) w_next = S_MEM_WRITE;
        else                      w_next = S_FETCH;
      end
      S_MEM_READ:  if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) w_next = S_FETCH;
      S_EXEC_R:    w_next = S_ALU_WB;
      S_EXEC_I:    w_next = S_IMM_WB;
      S_MEM_WB, S_ALU_WB, S_IMM_WB, S_BRANCH, S_JUMP, S_JR: w_next = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP:      w_next = S_TRAP;
`endif
      default:     w_next = S_FETCH;
    endcase
  end

  // Outputs forced low during reset even though the state register already reads FETCH.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    retire     = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
`ifndef CTRL_ILLEGAL_TRAP_EN
          retire    = w_illegal;
`endif
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          retire    = mem_ready;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        S_IMM_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 2'd1;
          pc_write  = alu_zero;
          retire    = 1'b1;
        end
        S_JUMP: begin
          pc_src   = 2'd2;
          pc_write = 1'b1;
          retire   = 1'b1;
        end
        S_JR: begin
          pc_src   = 2'd3;
          pc_write = 1'b1;
          retire   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = r_state;

endmodule
